// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and operand forwarding
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_opcode,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [3:0]      r_alu_op;
    logic            r_alu_src;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_branch;

    logic            w_hazard;
    logic [XLEN-1:0] w_cap_rs1;
    logic [XLEN-1:0] w_cap_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Load-use hazard: the load in EX produces data the decode slot needs next cycle.
    // Suppressed under external stall because no bubble would be inserted then.
    assign w_hazard = ~stall & r_valid & r_mem_read & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));

    // Register-file write-through at capture time so a same-cycle MEM/WB write is not missed
    always_comb begin
        w_cap_rs1 = id_rs1_data;
        w_cap_rs2 = id_rs2_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1)) w_cap_rs1 = memwb_result;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2)) w_cap_rs2 = memwb_result;
    end

    // Stage register: reset, then flush, then stall hold, then hazard bubble, then load
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && w_hazard)) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= 4'b0000;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
        end else if (!stall) begin
            r_valid     <= id_valid;
            r_pc        <= id_pc;
            r_rs1_data  <= w_cap_rs1;
            r_rs2_data  <= w_cap_rs2;
            r_imm       <= id_imm;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_alu_op    <= id_alu_op;
            r_alu_src   <= id_alu_src;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_branch    <= id_branch;
        end
    end

    // Execute-side forwarding: EX/MEM is younger so it beats MEM/WB; x0 is never forwarded
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs1))
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs1))
            w_fwd_rs1 = memwb_result;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs2))
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs2))
            w_fwd_rs2 = memwb_result;
    end

    assign hazard_stall  = w_hazard;
    assign ex_valid      = r_valid;
    assign ex_a          = w_fwd_rs1;
    assign ex_b          = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_opcode     = r_alu_op;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_branch     = r_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid;
    logic [63:0] ex_a, ex_b, ex_store_data, ex_pc;
    logic [3:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_opcode(ex_opcode), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        ewe;
        logic [4:0]  erd;
        logic [63:0] eres;
        logic        wwe;
        logic [4:0]  wrd;
        logic [63:0] wres;
    } fwd_t;

    // ctrl = {reg_write, mem_read, mem_write, branch}
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        src;
        logic [3:0]  ctrl;
        fwd_t        pre;
        fwd_t        post;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] esd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_fwd(input fwd_t f);
        exmem_reg_write = f.ewe;
        exmem_rd        = f.erd;
        exmem_result    = f.eres;
        memwb_reg_write = f.wwe;
        memwb_rd        = f.wrd;
        memwb_result    = f.wres;
    endtask

    task automatic drive_id(input logic [63:0] pc, input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [3:0] op, input logic src,
                            input logic [3:0] ctrl);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_alu_op    = op;
        id_alu_src   = src;
        id_reg_write = ctrl[3];
        id_mem_read  = ctrl[2];
        id_mem_write = ctrl[1];
        id_branch    = ctrl[0];
    endtask

    vec_t vecs [8];
    fwd_t f_none, f_p7, f_q7, f_z, f_w9, f_e6, f_mix;

    initial begin
        f_none = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0};
        f_p7   = '{1'b1, 5'd7, 64'h55, 1'b1, 5'd7, 64'h66};
        f_q7   = '{1'b0, 5'd7, 64'h55, 1'b1, 5'd7, 64'h66};
        f_z    = '{1'b1, 5'd0, 64'h99, 1'b1, 5'd0, 64'h77};
        f_w9   = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h1234};
        f_e6   = '{1'b1, 5'd6, 64'hABC, 1'b1, 5'd6, 64'hDEF};
        f_mix  = '{1'b1, 5'd14, 64'hAAA, 1'b1, 5'd15, 64'hBBB};

        //          pc        rs1d    rs2d    imm                     rs1    rs2    rd     op     src   ctrl     pre     post    ea        eb                      esd
        vecs[0] = '{64'h100, 64'd10, 64'd20, 64'd0,                  5'd3,  5'd4,  5'd1,  4'h0, 1'b0, 4'b1000, f_none, f_none, 64'd10,   64'd20,                 64'd20};
        vecs[1] = '{64'h104, 64'd10, 64'd20, 64'hFFFF_FFFF_FFFF_FFFB, 5'd3,  5'd4,  5'd1,  4'h8, 1'b1, 4'b1000, f_none, f_none, 64'd10,   64'hFFFF_FFFF_FFFF_FFFB, 64'd20};
        vecs[2] = '{64'h108, 64'd1,  64'd2,  64'd0,                  5'd7,  5'd8,  5'd2,  4'h0, 1'b0, 4'b1000, f_p7,   f_p7,   64'h55,   64'd2,                  64'd2};
        vecs[3] = '{64'h10C, 64'd1,  64'd2,  64'd0,                  5'd7,  5'd8,  5'd2,  4'h0, 1'b0, 4'b1000, f_q7,   f_q7,   64'h66,   64'd2,                  64'd2};
        vecs[4] = '{64'h110, 64'd0,  64'd3,  64'd0,                  5'd0,  5'd10, 5'd4,  4'h2, 1'b0, 4'b1000, f_z,    f_z,    64'd0,    64'd3,                  64'd3};
        vecs[5] = '{64'h114, 64'd0,  64'd5,  64'd0,                  5'd9,  5'd11, 5'd12, 4'h0, 1'b0, 4'b1000, f_w9,   f_none, 64'h1234, 64'd5,                  64'd5};
        vecs[6] = '{64'h118, 64'd7,  64'd1,  64'h10,                 5'd13, 5'd6,  5'd0,  4'h0, 1'b1, 4'b0010, f_none, f_e6,   64'd7,    64'h10,                 64'hABC};
        vecs[7] = '{64'h11C, 64'd1,  64'd2,  64'd0,                  5'd14, 5'd15, 5'd3,  4'hD, 1'b0, 4'b1001, f_none, f_mix,  64'hAAA,  64'hBBB,                64'hBBB};

        // Reset with every decode input nonzero
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        set_fwd(f_none);
        drive_id(64'hDEAD, 64'h11, 64'h22, 64'h33, 5'd5, 5'd6, 5'd7, 4'hF, 1'b1, 4'b1111);
        @(posedge clk); #1;
        chk("rst_valid",  64'(ex_valid), 64'd0);
        chk("rst_opcode", 64'(ex_opcode), 64'd0);
        chk("rst_a",      ex_a, 64'd0);
        chk("rst_b",      ex_b, 64'd0);
        chk("rst_hazard", 64'(hazard_stall), 64'd0);
        chk("rst_pc",     ex_pc, 64'd0);
        chk("rst_ctrl",   64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 64'd0);
        reset = 1'b0;

        // Table: pre-edge forward state drives write-through, post-edge state drives EX forwarding
        for (int i = 0; i < 8; i++) begin
            drive_id(vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, vecs[i].rs1,
                     vecs[i].rs2, vecs[i].rd, vecs[i].op, vecs[i].src, vecs[i].ctrl);
            set_fwd(vecs[i].pre);
            @(posedge clk); #1;
            set_fwd(vecs[i].post);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'd1);
            chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_opcode", i), 64'(ex_opcode), 64'(vecs[i].op));
            chk($sformatf("v%0d_ctrl", i), 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 64'(vecs[i].ctrl));
            chk($sformatf("v%0d_a", i), ex_a, vecs[i].ea);
            chk($sformatf("v%0d_b", i), ex_b, vecs[i].eb);
            chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].esd);
            chk($sformatf("v%0d_hazard", i), 64'(hazard_stall), 64'd0);
        end

        // Stall holds everything while decode keeps changing
        set_fwd(f_none);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_id(64'h500 + 64'(k), 64'h77, 64'h88, 64'h99, 5'd20, 5'd21, 5'd22, 4'h5, 1'b1, 4'b0101);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_pc", k), ex_pc, 64'h11C);
            chk($sformatf("stall%0d_opcode", k), 64'(ex_opcode), 64'hD);
            chk($sformatf("stall%0d_a", k), ex_a, 64'd1);
            chk($sformatf("stall%0d_valid", k), 64'(ex_valid), 64'd1);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        stall = 1'b0;
        chk("stallflush_valid", 64'(ex_valid), 64'd0);
        chk("stallflush_regwr", 64'(ex_reg_write), 64'd0);
        chk("stallflush_pc", ex_pc, 64'd0);

        // Load-use hazard: load rd=5, dependent reads rs2=5
        drive_id(64'h200, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd5, 4'h0, 1'b0, 4'b1100);
        @(posedge clk); #1;
        chk("ld_memread", 64'(ex_mem_read), 64'd1);
        drive_id(64'h204, 64'd3, 64'd4, 64'd0, 5'd3, 5'd5, 5'd6, 4'h0, 1'b0, 4'b1000);
        #1;
        chk("haz_assert", 64'(hazard_stall), 64'd1);
        stall = 1'b1;
        #1;
        chk("haz_masked_by_stall", 64'(hazard_stall), 64'd0);
        stall = 1'b0;
        #1;
        chk("haz_reassert", 64'(hazard_stall), 64'd1);
        @(posedge clk); #1;
        chk("bubble_valid", 64'(ex_valid), 64'd0);
        chk("bubble_memread", 64'(ex_mem_read), 64'd0);
        chk("bubble_hazard", 64'(hazard_stall), 64'd0);
        @(posedge clk); #1;
        chk("dep_valid", 64'(ex_valid), 64'd1);
        chk("dep_pc", ex_pc, 64'h204);
        chk("dep_hazard", 64'(hazard_stall), 64'd0);

        // Flush during a hazard yields a single bubble, then the dependent loads
        drive_id(64'h300, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd5, 4'h0, 1'b0, 4'b1100);
        @(posedge clk); #1;
        drive_id(64'h304, 64'd3, 64'd4, 64'd0, 5'd5, 5'd2, 5'd6, 4'h0, 1'b0, 4'b1000);
        #1;
        chk("fh_hazard", 64'(hazard_stall), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fh_bubble_valid", 64'(ex_valid), 64'd0);
        chk("fh_bubble_pc", ex_pc, 64'd0);
        @(posedge clk); #1;
        chk("fh_dep_valid", 64'(ex_valid), 64'd1);
        chk("fh_dep_pc", ex_pc, 64'h304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
